// File: rtl/mult_fu_pkg.sv
// Shared types for the pipelined RV32M multiply unit: issue packet, function
// encoding and the per-stage partial-product record.
package mult_fu_pkg;

  localparam int DATA_W          = 32;
  localparam int PHYS_REG_W      = 6;
  localparam int MULT_STAGES_DEF = 4;
  localparam int NUM_FU_MULT     = 2;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [PHYS_REG_W-1:0] phys_reg_t;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_e;

  typedef struct packed {
    logic       valid;
    data_t      rs1_value;
    data_t      rs2_value;
    mult_func_e func;
    phys_reg_t  dest_reg_idx;
  } mult_packet_t;

  typedef struct packed {
    logic        valid;
    mult_func_e  func;
    phys_reg_t   dest;
    logic [63:0] product;
    logic [63:0] mcand;
    logic [63:0] mplier;
  } mult_stage_t;

  function automatic logic [63:0] extend64(data_t v, logic is_signed);
    return {{32{is_signed & v[31]}}, v};
  endfunction

endpackage

// File: rtl/mult_fu_if.sv
// Issue-to-FU packet lane plus the CDB request/grant pair of one multiply unit.
interface mult_fu_if
  import mult_fu_pkg::*;
  ;
  mult_packet_t mult_packet;
  logic         mult_free;
  logic         cdb_req;
  logic         cdb_gnt;
  data_t        cdb_result;
  phys_reg_t    cdb_dest_reg;

  modport master (
    output mult_packet, cdb_gnt,
    input  mult_free, cdb_req, cdb_result, cdb_dest_reg
  );

  modport slave (
    input  mult_packet, cdb_gnt,
    output mult_free, cdb_req, cdb_result, cdb_dest_reg
  );
endinterface

// File: rtl/mult_fu_stage.sv
// One partial-product stage: folds STEP multiplier bits into the running
// product and shifts the operands for the next stage.
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int STEP = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  mult_stage_t stage_i,
  output mult_stage_t stage_o
);

  mult_stage_t stage_d, stage_q;

  // NOTE: default every field to the held value first so no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d         = stage_i;
      stage_d.product = stage_i.product + stage_i.mcand * 64'(stage_i.mplier[STEP-1:0]);
      stage_d.mcand   = stage_i.mcand << STEP;
      stage_d.mplier  = stage_i.mplier >> STEP;
    end
    if (flush) stage_d.valid = 1'b0;
  end

  // NOTE: only the valid bit is reset; the payload is meaningless while valid=0.
  always_ff @(posedge clock) begin
    if (reset) stage_q.valid <= 1'b0;
    else       stage_q       <= stage_d;
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: operand prep, MULT_STAGES partial-product
// stages, result select and CDB stall/backpressure.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic squash,
  mult_fu_if.slave fu
);

  localparam int STEP = 64 / MULT_STAGES;

  mult_stage_t                   prep;
  mult_stage_t [MULT_STAGES-1:0] stage_out;
  mult_stage_t                   fin;
  logic                          stall;
  logic [127:0]                  fin_unused;

  assign fin        = stage_out[MULT_STAGES-1];
  assign fin_unused = {fin.mcand, fin.mplier};

  // A held result freezes the whole pipe; a grant lets it advance this cycle.
  assign stall        = fin.valid & ~fu.cdb_gnt;
  assign fu.mult_free = ~stall;

  always_comb begin
    prep         = '0;
    prep.valid   = fu.mult_packet.valid & ~stall;
    prep.func    = fu.mult_packet.func;
    prep.dest    = fu.mult_packet.dest_reg_idx;
    prep.mcand   = extend64(fu.mult_packet.rs1_value, fu.mult_packet.func != MULHU);
    prep.mplier  = extend64(fu.mult_packet.rs2_value,
                            (fu.mult_packet.func == MUL) || (fu.mult_packet.func == MULH));
  end

  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_stage
    mult_stage_t stage_in;
    if (k == 0) begin : g_first
      assign stage_in = prep;
    end else begin : g_next
      assign stage_in = stage_out[k-1];
    end

    mult_stage #(.STEP(STEP)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en      (~stall),
      .flush   (squash),
      .stage_i (stage_in),
      .stage_o (stage_out[k])
    );
  end

  always_comb begin
    fu.cdb_req      = fin.valid;
    fu.cdb_result   = '0;
    fu.cdb_dest_reg = '0;
    if (fin.valid) begin
      fu.cdb_result   = (fin.func == MUL) ? fin.product[31:0] : fin.product[63:32];
      fu.cdb_dest_reg = fin.dest;
    end
  end

  // Issue must not present a packet while the unit is busy; it is dropped.
  a_no_issue_when_busy : assert property (
    @(posedge clock) disable iff (reset) !(fu.mult_packet.valid && !fu.mult_free)
  ) else $warning("mult_fu: packet presented while mult_free=0, ignored");

endmodule
